// File: rtl/code_lock_ctrl.sv
// Code-lock sequencing FSM: gathers a complete switch entry, checks it against the
// stored password, and drives unlock/alarm timing, lockout and password change.
module code_lock_ctrl #(
   parameter int          BYTE          = 4,
   parameter int          MAX_FAIL      = 3,
   parameter int          UNLOCK_CYCLES = 20,
   parameter int          LOCK_CYCLES   = 50,
   parameter logic [15:0] DEFAULT_PW    = 16'h1234
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] Code,
   input  logic [2:0]  Code_Bit,
   input  logic        Enter,
   input  logic        Mode_Set,
   output logic        Unlock,
   output logic        Alarm,
   output logic        Clear_Req,
   output logic        Pw_Updated,
   output logic [1:0]  Fail_Cnt,
   output logic [2:0]  State
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_FAIL    = 3'd4,
      S_LOCKOUT = 3'd5,
      S_SET_NEW = 3'd6
   } state_t;

   state_t      r_state;
   logic [15:0] r_pw;
   logic [31:0] r_timer;
   logic [1:0]  r_fail;
   logic        r_clear;
   logic        r_pw_upd;

   logic        w_full;
   logic        w_match;
   logic [1:0]  w_fail_next;

   assign w_full      = (Code_Bit == 3'(BYTE));
   assign w_match     = (Code == r_pw);
   assign w_fail_next = (r_fail == 2'(MAX_FAIL)) ? r_fail : r_fail + 2'd1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_pw     <= DEFAULT_PW;
         r_timer  <= '0;
         r_fail   <= '0;
         r_clear  <= 1'b0;
         r_pw_upd <= 1'b0;
      end else begin
         // Pulses default low; timer restarts from zero whenever a timed state is entered.
         r_clear  <= 1'b0;
         r_pw_upd <= 1'b0;
         r_timer  <= '0;
         case (r_state)
            S_IDLE: begin
               if (Code_Bit != 3'd0)
                  r_state <= S_ENTRY;
            end
            S_ENTRY: begin
               if (Enter)
                  r_state <= w_full ? S_CHECK : S_FAIL;
               else if (Code_Bit == 3'd0)
                  r_state <= S_IDLE;
            end
            S_CHECK: begin
               if (w_match) begin
                  r_fail <= '0;
                  if (Mode_Set) begin
                     r_state <= S_SET_NEW;
                     r_clear <= 1'b1;
                  end else begin
                     r_state <= S_OPEN;
                  end
               end else begin
                  r_state <= S_FAIL;
               end
            end
            S_OPEN: begin
               if (r_timer == 32'(UNLOCK_CYCLES - 1)) begin
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
            S_FAIL: begin
               r_fail <= w_fail_next;
               if (w_fail_next == 2'(MAX_FAIL)) begin
                  r_state <= S_LOCKOUT;
               end else begin
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
               end
            end
            S_LOCKOUT: begin
               if (r_timer == 32'(LOCK_CYCLES - 1)) begin
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
                  r_fail  <= '0;
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
            S_SET_NEW: begin
               // A short entry abandons the change without counting as a failure.
               if (Enter) begin
                  if (w_full) begin
                     r_pw     <= Code;
                     r_pw_upd <= 1'b1;
                  end
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Unlock     = (r_state == S_OPEN);
   assign Alarm      = (r_state == S_LOCKOUT);
   assign Clear_Req  = r_clear;
   assign Pw_Updated = r_pw_upd;
   assign Fail_Cnt   = r_fail;
   assign State      = r_state;

endmodule
